// File: rtl/rom_pkg.sv
// Shared definitions for the lookup ROM and its burst reader.
// Provides ROM geometry defaults, burst-length width and the reader FSM state type.
package rom_pkg;

    localparam int ROM_AW = 3;
    localparam int ROM_DW = 8;
    localparam int ROM_LW = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO holding words returned by the ROM.
// Ports: clk, rst (sync, active-high), push/push_data, pop, head (oldest word), count (0..2).
module sync_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                // Second entry moves up; a concurrent push refills behind it.
                if (count == 2'd2) begin
                    head <= tail;
                    if (push) begin
                        tail <= push_data;
                    end
                end else if (push) begin
                    head <= push_data;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head <= push_data;
                end else begin
                    tail <= push_data;
                end
            end
        end
    end

endmodule

// File: rtl/rom_reader.sv
// Burst read initiator for the synchronous lookup ROM, streaming words over valid/ready.
// Ports: clk, rst; start/start_addr/length command; busy, done status;
// rom_addr/rom_en/rom_data ROM port; out_data/out_valid/out_ready stream.
module rom_reader
    import rom_pkg::*;
#(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW,
    parameter int LW = ROM_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rom_addr,
    output logic          rom_en,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] last_addr;
    logic [LW-1:0] remain;
    logic          inflight;

    logic [DW-1:0] head;
    logic [1:0]    fifo_cnt;
    logic          fifo_nz;
    logic          fifo_push;
    logic          fifo_pop;
    logic          pop;
    logic          issue;
    logic          last_pop;
    logic [2:0]    held;

    assign fifo_nz   = (fifo_cnt != 2'd0);

    // The word returning from the ROM is offered directly while the FIFO
    // is empty, so output valid follows rom_en by exactly one cycle.
    assign out_valid = fifo_nz | inflight;
    assign out_data  = (!fifo_nz && inflight) ? rom_data : head;
    assign pop       = out_valid & out_ready;

    assign fifo_pop  = pop & fifo_nz;
    assign fifo_push = inflight & ~(pop & ~fifo_nz);

    // Words still held after this cycle; a new issue may only add one
    // while the total stays within the two buffer slots.
    assign held      = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == RUN) && (remain != '0) && (held < 3'd2);
    assign last_pop  = pop && (held == 3'd0);

    assign rom_en    = issue;
    assign rom_addr  = issue ? addr_q : last_addr;

    sync_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (rom_data),
        .pop       (fifo_pop),
        .head      (head),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_q    <= '0;
            last_addr <= '0;
            remain    <= '0;
            inflight  <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                addr_q    <= addr_q + AW'(1);
                last_addr <= addr_q;
                remain    <= remain - LW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_q <= start_addr;
                            remain <= length;
                            state  <= RUN;
                            busy   <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (remain == LW'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a behavioural ROM holding mem[a] = a+1.
// Outputs are sampled 1 time unit after the falling edge, inputs driven at the falling edge.
module tb_rom_reader;
    import rom_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] length;
    logic       busy;
    logic       done;
    logic [2:0] rom_addr;
    logic       rom_en;
    logic [7:0] rom_data = 8'd0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    logic [7:0] got[$];

    always #5 clk = ~clk;

    // Registered ROM output: word for the address presented while rom_en is high.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_data <= {5'd0, rom_addr} + 8'd1;
        end
    end

    rom_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_en"}, int'(rom_en), 0);
        chk({tag, "_addr"}, int'(rom_addr), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_data"}, int'(out_data), 0);
    endtask

    task automatic go(input logic [2:0] sa, input logic [3:0] len);
        @(negedge clk);
        start      = 1'b1;
        start_addr = sa;
        length     = len;
        out_ready  = 1'b0;
        got.delete();
    endtask

    // Cycle-exact burst with out_ready held high; k counts cycles after acceptance.
    task automatic timed_burst(input string tag, input logic [2:0] sa, input int n);
        logic [2:0] ea;
        logic [2:0] da;
        @(negedge clk);
        start      = 1'b1;
        start_addr = sa;
        length     = 4'(n);
        out_ready  = 1'b1;
        for (int k = 1; k <= n + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            ea = sa + 3'(k - 1);
            da = sa + 3'(k - 2);
            chk({tag, "_en"}, int'(rom_en), int'(k <= n));
            if (k <= n) chk({tag, "_addr"}, int'(rom_addr), int'(ea));
            chk({tag, "_valid"}, int'(out_valid), int'(k >= 2 && k <= n + 1));
            if (k >= 2 && k <= n + 1) chk({tag, "_data"}, int'(out_data), int'(da) + 1);
            chk({tag, "_done"}, int'(done), int'(k == n + 2));
            chk({tag, "_busy"}, int'(busy), int'(k >= 1 && k <= n + 1));
        end
    endtask

    // Runs until done with out_ready high pct% of cycles, recording consumed words.
    task automatic drain(input string tag, input int pct, input int pulse_at,
                         output int en_cnt);
        bit         seen;
        bit         hold;
        logic [7:0] hd;
        seen   = 1'b0;
        hold   = 1'b0;
        hd     = 8'd0;
        en_cnt = 0;
        for (int c = 0; c < 120 && !seen; c++) begin
            @(negedge clk);
            start      = (c == pulse_at);
            start_addr = 3'd5;
            length     = 4'd2;
            out_ready  = ($urandom_range(99) < pct);
            #1;
            if (hold) begin
                chk({tag, "_hold_valid"}, int'(out_valid), 1);
                chk({tag, "_hold_data"}, int'(out_data), int'(hd));
            end
            en_cnt += int'(rom_en);
            if (out_valid && out_ready) got.push_back(out_data);
            hold = out_valid && !out_ready;
            hd   = out_data;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, int'(seen), 1);
        if (seen) n_done++;
    endtask

    task automatic verify(input string tag, input logic [2:0] sa, input int len,
                          input int en_cnt);
        logic [2:0] a;
        chk({tag, "_nwords"}, got.size(), len);
        chk({tag, "_reads"}, en_cnt, len);
        for (int i = 0; i < got.size() && i < len; i++) begin
            a = sa + 3'(i);
            chk({tag, "_word"}, int'(got[i]), int'(a) + 1);
        end
    endtask

    initial begin
        int en;
        int en2;
        int done_base;
        logic [2:0] rsa;
        logic [3:0] rlen;

        rst        = 1'b1;
        start      = 1'b0;
        start_addr = 3'd0;
        length     = 4'd0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b0;

        // Basic burst and address wrap.
        timed_burst("basic", 3'd3, 4);
        timed_burst("wrap", 3'd6, 4);

        // Backpressure: six stalled cycles, then free flow.
        go(3'd0, 4'd5);
        en = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start     = 1'b0;
            out_ready = 1'b0;
            #1;
            en += int'(rom_en);
            if (k >= 2) begin
                chk("bp_stall_valid", int'(out_valid), 1);
                chk("bp_stall_data", int'(out_data), 1);
            end
        end
        chk("bp_stall_reads", en, 2);
        drain("bp", 100, -1, en2);
        verify("bp", 3'd0, 5, en + en2);

        // Zero-length command.
        go(3'd4, 4'd0);
        #1;
        chk("zero_en0", int'(rom_en), 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 0);
        chk("zero_en1", int'(rom_en), 0);
        @(negedge clk);
        #1;
        chk("zero_done_once", int'(done), 0);

        // Start pulsed mid-burst is ignored.
        go(3'd0, 4'd3);
        drain("busy", 100, 1, en);
        verify("busy", 3'd0, 3, en);
        @(negedge clk);
        #1;
        chk("busy_no_queue_en", int'(rom_en), 0);
        chk("busy_no_queue_busy", int'(busy), 0);

        // Reset after two consumed words.
        go(3'd0, 4'd6);
        for (int c = 0; c < 20 && got.size() < 2; c++) begin
            @(negedge clk);
            start     = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) got.push_back(out_data);
        end
        chk("mid_two_words", got.size(), 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset("mid");
        en = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            en += int'(done) + int'(out_valid) + int'(rom_en);
        end
        chk("mid_quiet", en, 0);
        go(3'd2, 4'd1);
        drain("after", 100, -1, en);
        verify("after", 3'd2, 1, en);

        // Random lengths, addresses and ready toggling.
        done_base = n_done;
        for (int b = 0; b < 200; b++) begin
            rsa  = 3'($urandom_range(7));
            rlen = 4'($urandom_range(15));
            go(rsa, rlen);
            drain("rand", 50, -1, en);
            verify("rand", rsa, int'(rlen), en);
        end
        chk("rand_done_count", n_done - done_base, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
